spi_minion_shifter: RTL and testbench

SPI minion (mode 0, MSB first) shift engine that consumes the already-synchronized chip-select, SCLK edge pulses and MOSI level produced by the per-pin synchronizer stage. It deserializes one nbits-wide word per chip-select frame and serializes a buffered transmit word onto MISO. On the parallel side it presents a valid/ready transmit buffer to the core logic and a one-cycle received-word strobe back to it.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_minion_shifter_if.sv | 36 +++
 rtl/spi_tx_buffer.sv | 33 +++
 rtl/spi_minion_shifter.sv | 95 +++++++++
 tb/tb_spi_minion_shifter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI minion types.
// Frame state is reused by the minion top level.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 2);
    endfunction

endpackage

// File: rtl/spi_minion_shifter_if.sv
// Serial pin events plus parallel transmit/receive side
// of the SPI minion shift engine.
interface spi_minion_shifter_if #(
    parameter int nbits = 8
);
    logic             cs;
    logic             cs_negedge;
    logic             cs_posedge;
    logic             sclk_posedge;
    logic             sclk_negedge;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [nbits-1:0] send_msg;
    logic             send_val;
    logic             send_rdy;
    logic [nbits-1:0] recv_msg;
    logic             recv_val;
    logic             frame_err;

    modport master (
        output cs, cs_negedge, cs_posedge,
        output sclk_posedge, sclk_negedge, mosi,
        output send_msg, send_val,
        input  miso, miso_oe, send_rdy,
        input  recv_msg, recv_val, frame_err
    );

    modport slave (
        input  cs, cs_negedge, cs_posedge,
        input  sclk_posedge, sclk_negedge, mosi,
        input  send_msg, send_val,
        output miso, miso_oe, send_rdy,
        output recv_msg, recv_val, frame_err
    );
endinterface

// File: rtl/spi_tx_buffer.sv
// Single-entry transmit holding register.
// A load in the consume cycle survives for the next frame.
module spi_tx_buffer #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] load_msg,
    input  logic             load_val,
    output logic             load_rdy,
    input  logic             consume,
    output logic             full,
    output logic [nbits-1:0] msg
);
    logic load;

    assign load     = load_val && !full;
    assign load_rdy = !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            msg  <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                msg  <= load_msg;
            end else if (consume) begin
                full <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/spi_minion_shifter.sv
// SPI mode 0 minion shift engine, MSB first.
// One word per chip-select frame, buffered transmit word.
module spi_minion_shifter
    import spi_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic clk,
    input  logic reset,
    spi_minion_shifter_if.slave bus
);
    localparam int BW = cnt_width(nbits);
    localparam logic [BW-1:0] CNT_FULL = BW'(nbits);
    localparam logic [BW-1:0] CNT_MAX  = BW'(nbits + 1);

    state_t           state;
    state_t           state_next;
    logic [nbits-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic [nbits-1:0] recv_q;
    logic             recv_val_q;
    logic             frame_err_q;
    logic             tx_full;
    logic [nbits-1:0] tx_msg;
    logic             tx_rdy;
    logic             start;
    logic             fin;
    logic             good;
    logic             shift;
    logic             unused_ok;

    assign unused_ok = bus.sclk_negedge;

    assign start = (state == IDLE) && bus.cs_negedge && !bus.cs;
    assign fin   = (state == ACTIVE)
                && (bus.cs_posedge || bus.cs_negedge);
    // A chip-select glitch mid-frame always counts as a bad frame.
    assign good  = (bitcnt == CNT_FULL) && !bus.cs_negedge;
    assign shift = (state == ACTIVE) && !fin && bus.sclk_posedge;

    spi_tx_buffer #(.nbits(nbits)) u_txbuf (
        .clk      (clk),
        .reset    (reset),
        .load_msg (bus.send_msg),
        .load_val (bus.send_val),
        .load_rdy (tx_rdy),
        .consume  (start),
        .full     (tx_full),
        .msg      (tx_msg)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = ACTIVE;
            ACTIVE: if (fin)   state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            bitcnt      <= '0;
            recv_q      <= '0;
            recv_val_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            recv_val_q  <= fin && good;
            frame_err_q <= fin && !good;
            if (fin && good) recv_q <= shreg;
            if (start) begin
                shreg  <= tx_full ? tx_msg : '0;
                bitcnt <= '0;
            end else if (shift) begin
                shreg <= {shreg[nbits-2:0], bus.mosi};
                if (bitcnt != CNT_MAX) bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.miso      = (state == ACTIVE) ? shreg[nbits-1] : 1'b0;
        bus.miso_oe   = (state == ACTIVE);
        bus.send_rdy  = tx_rdy;
        bus.recv_msg  = recv_q;
        bus.recv_val  = recv_val_q;
        bus.frame_err = frame_err_q;
    end
endmodule

// File: tb/tb_spi_minion_shifter.sv
// Directed bench for spi_minion_shifter.
// Expected values are hand-computed per step.
module tb_spi_minion_shifter;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    spi_minion_shifter_if #(.nbits(8)) bus ();

    spi_minion_shifter #(.nbits(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        bus.cs = 1'b0;
        bus.cs_negedge = 1'b1;
        tick();
        bus.cs_negedge = 1'b0;
    endtask

    task automatic end_frame();
        bus.cs = 1'b1;
        bus.cs_posedge = 1'b1;
        tick();
        bus.cs_posedge = 1'b0;
    endtask

    task automatic sclk_bit(input logic b);
        bus.mosi = b;
        bus.sclk_posedge = 1'b1;
        tick();
        bus.sclk_posedge = 1'b0;
        bus.sclk_negedge = 1'b1;
        tick();
        bus.sclk_negedge = 1'b0;
        tick();
    endtask

    task automatic run_bits(input logic [15:0] word, input int n,
                            output logic [15:0] mis);
        logic [15:0] w;
        w = word;
        mis = '0;
        for (int i = 0; i < n; i++) begin
            mis = {mis[14:0], bus.miso};
            sclk_bit(w[n-1-i]);
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.send_msg = d;
        bus.send_val = 1'b1;
        tick();
        bus.send_val = 1'b0;
    endtask

    initial begin
        logic [15:0] mis;
        n_assert = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.cs = 1'b1;
        bus.cs_negedge = 1'b0;
        bus.cs_posedge = 1'b0;
        bus.sclk_posedge = 1'b0;
        bus.sclk_negedge = 1'b0;
        bus.mosi = 1'b0;
        bus.send_msg = '0;
        bus.send_val = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_miso", 16'(bus.miso), 16'h0);
        chk("rst_oe", 16'(bus.miso_oe), 16'h0);
        chk("rst_rdy", 16'(bus.send_rdy), 16'h1);
        chk("rst_recv", 16'(bus.recv_msg), 16'h0);
        chk("rst_rval", 16'(bus.recv_val), 16'h0);
        chk("rst_err", 16'(bus.frame_err), 16'h0);

        // frame 1: tx 0x3C, rx 0xA5
        send(8'h3C);
        chk("f1_rdy_lo", 16'(bus.send_rdy), 16'h0);
        start_frame();
        chk("f1_oe", 16'(bus.miso_oe), 16'h1);
        chk("f1_rdy_hi", 16'(bus.send_rdy), 16'h1);
        run_bits(16'hA5, 8, mis);
        chk("f1_miso", mis, 16'h3C);
        end_frame();
        chk("f1_rval", 16'(bus.recv_val), 16'h1);
        chk("f1_recv", 16'(bus.recv_msg), 16'hA5);
        chk("f1_err", 16'(bus.frame_err), 16'h0);
        tick();
        chk("f1_rval_off", 16'(bus.recv_val), 16'h0);
        chk("f1_oe_off", 16'(bus.miso_oe), 16'h0);
        chk("f1_hold", 16'(bus.recv_msg), 16'hA5);

        // frame 2: empty buffer
        start_frame();
        run_bits(16'h5A, 8, mis);
        chk("f2_miso", mis, 16'h0);
        chk("f2_rdy", 16'(bus.send_rdy), 16'h1);
        end_frame();
        chk("f2_rval", 16'(bus.recv_val), 16'h1);
        chk("f2_recv", 16'(bus.recv_msg), 16'h5A);
        tick();

        // short frame
        start_frame();
        run_bits(16'h1F, 5, mis);
        end_frame();
        chk("short_err", 16'(bus.frame_err), 16'h1);
        chk("short_rval", 16'(bus.recv_val), 16'h0);
        chk("short_recv", 16'(bus.recv_msg), 16'h5A);
        tick();
        chk("short_err_off", 16'(bus.frame_err), 16'h0);

        // long frame
        start_frame();
        run_bits(16'h2AB, 10, mis);
        end_frame();
        chk("long_err", 16'(bus.frame_err), 16'h1);
        chk("long_rval", 16'(bus.recv_val), 16'h0);
        chk("long_recv", 16'(bus.recv_msg), 16'h5A);
        tick();

        // cs_posedge coincident with 8th sclk posedge
        start_frame();
        run_bits(16'h7F, 7, mis);
        bus.mosi = 1'b1;
        bus.sclk_posedge = 1'b1;
        bus.cs = 1'b1;
        bus.cs_posedge = 1'b1;
        tick();
        bus.sclk_posedge = 1'b0;
        bus.cs_posedge = 1'b0;
        chk("coin_err", 16'(bus.frame_err), 16'h1);
        chk("coin_rval", 16'(bus.recv_val), 16'h0);
        chk("coin_recv", 16'(bus.recv_msg), 16'h5A);
        tick();

        // send during active frame
        start_frame();
        run_bits(16'h3, 2, mis);
        chk("act_miso_a", mis, 16'h0);
        send(8'h81);
        chk("act_rdy_lo", 16'(bus.send_rdy), 16'h0);
        run_bits(16'h03, 6, mis);
        chk("act_miso_b", mis, 16'h0);
        end_frame();
        chk("act_recv", 16'(bus.recv_msg), 16'hC3);
        chk("act_rval", 16'(bus.recv_val), 16'h1);
        tick();
        chk("act_rdy_hold", 16'(bus.send_rdy), 16'h0);
        start_frame();
        chk("nxt_rdy_hi", 16'(bus.send_rdy), 16'h1);
        run_bits(16'h00, 8, mis);
        chk("nxt_miso", mis, 16'h81);
        end_frame();
        chk("nxt_recv", 16'(bus.recv_msg), 16'h00);
        tick();

        // send on the cs_negedge cycle
        bus.send_msg = 8'h96;
        bus.send_val = 1'b1;
        start_frame();
        bus.send_val = 1'b0;
        chk("neg_rdy_lo", 16'(bus.send_rdy), 16'h0);
        run_bits(16'h3C, 8, mis);
        chk("neg_miso", mis, 16'h0);
        end_frame();
        chk("neg_recv", 16'(bus.recv_msg), 16'h3C);
        tick();
        start_frame();
        run_bits(16'hFF, 8, mis);
        chk("neg_nxt_miso", mis, 16'h96);
        end_frame();
        chk("neg_nxt_recv", 16'(bus.recv_msg), 16'hFF);
        tick();

        // cs glitch while active, then stray cs_posedge in IDLE
        start_frame();
        run_bits(16'h11, 8, mis);
        bus.cs_negedge = 1'b1;
        tick();
        bus.cs_negedge = 1'b0;
        chk("glitch_err", 16'(bus.frame_err), 16'h1);
        chk("glitch_rval", 16'(bus.recv_val), 16'h0);
        chk("glitch_oe", 16'(bus.miso_oe), 16'h0);
        chk("glitch_recv", 16'(bus.recv_msg), 16'hFF);
        end_frame();
        chk("idle_pos_err", 16'(bus.frame_err), 16'h0);
        chk("idle_pos_rval", 16'(bus.recv_val), 16'h0);
        tick();

        // reset after 4 bits with a buffered word
        start_frame();
        run_bits(16'hB, 4, mis);
        send(8'h55);
        chk("rmid_rdy_lo", 16'(bus.send_rdy), 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cs = 1'b1;
        chk("rmid_oe", 16'(bus.miso_oe), 16'h0);
        chk("rmid_rdy", 16'(bus.send_rdy), 16'h1);
        chk("rmid_rval", 16'(bus.recv_val), 16'h0);
        chk("rmid_err", 16'(bus.frame_err), 16'h0);
        tick();
        chk("rmid_rval2", 16'(bus.recv_val), 16'h0);
        chk("rmid_err2", 16'(bus.frame_err), 16'h0);
        start_frame();
        run_bits(16'hE7, 8, mis);
        chk("rmid_miso", mis, 16'h0);
        end_frame();
        chk("rmid_recv", 16'(bus.recv_msg), 16'hE7);
        chk("rmid_rval3", 16'(bus.recv_val), 16'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
